// File: rtl/vector_data_mem.sv
// Data-memory responder for the execute-stage load/store port: scalar and
// VLEN-element vector accesses against a single-port word array.
//
// state | meaning
// IDLE  | port free; scalar requests complete here, vector element 0 issued here
// BURST | vector in flight; one element per cycle, new requests held off
module vector_data_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int VLEN   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic                     req_vec,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W*VLEN-1:0]   req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W*VLEN-1:0]   rsp_data,
  output logic                     stall
);

  localparam int   AW    = $clog2(DEPTH);
  localparam int   CW    = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic MULTI = (VLEN > 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, stateNext;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [VLEN-1:0][DATA_W-1:0] latchData;
  logic [VLEN-1:0][DATA_W-1:0] vecBuf;
  logic [VLEN-1:0][DATA_W-1:0] rspData;
  logic [AW-1:0]               baseIdx;
  logic [AW-1:0]               memIdx;
  logic [CW-1:0]               cnt;
  logic [DATA_W-1:0]           memWdata;
  logic [DATA_W-1:0]           memRdata;
  logic                        latchWe;
  logic                        accept;
  logic                        memWe;
  logic                        lastElem;
  logic                        rspValid;
  logic                        unusedAddrBits;

  // Address bits above the array size only alias; they are deliberately ignored.
  assign unusedAddrBits = ^req_addr[ADDR_W-1:AW];

  assign req_ready = (state == IDLE);
  assign stall     = !req_ready;
  assign accept    = req_valid && req_ready && !reset;
  assign lastElem  = (state == BURST) && (cnt == CW'(VLEN - 1));
  assign memRdata  = mem[memIdx];
  assign rsp_valid = rspValid;
  assign rsp_data  = rspData;

  always_comb begin
    stateNext = state;
    memIdx    = baseIdx + AW'(cnt);
    memWdata  = latchData[cnt];
    memWe     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          memIdx   = req_addr[AW-1:0];
          memWdata = req_wdata[DATA_W-1:0];
          memWe    = req_we;
          if (req_vec && MULTI) stateNext = BURST;
        end
      end
      BURST: begin
        memWe = latchWe && !reset;
        if (lastElem) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= memWdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rspValid  <= 1'b0;
      rspData   <= '0;
      cnt       <= '0;
      baseIdx   <= '0;
      latchWe   <= 1'b0;
      latchData <= '0;
      vecBuf    <= '0;
    end else begin
      rspValid <= 1'b0;
      if (accept) begin
        if (req_vec && MULTI) begin
          baseIdx   <= req_addr[AW-1:0];
          latchWe   <= req_we;
          latchData <= req_wdata;
          cnt       <= CW'(1);
          vecBuf    <= '0;
          if (!req_we) vecBuf[0] <= memRdata;
        end else begin
          rspValid <= 1'b1;
          rspData  <= '0;
          if (!req_we) rspData[0] <= memRdata;
        end
      end else if (state == BURST) begin
        if (lastElem) begin
          // Final element bypasses vecBuf so the response lands this edge.
          rspValid <= 1'b1;
          cnt      <= '0;
          if (latchWe) begin
            rspData <= '0;
          end else begin
            rspData      <= vecBuf;
            rspData[cnt] <= memRdata;
          end
        end else begin
          if (!latchWe) vecBuf[cnt] <= memRdata;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_data_mem.sv
// Randomized scoreboard bench for vector_data_mem: the driver applies each
// accepted request atomically to a word-array model and queues the response.
module tb_vector_data_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int VLEN   = 4;
  localparam int DEPTH  = 1024;
  localparam int VW     = DATA_W * VLEN;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic              req_vec = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [VW-1:0]     req_wdata = '0;
  logic              rsp_valid;
  logic [VW-1:0]     rsp_data;
  logic              stall;

  vector_data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [VW-1:0] data;
    int            due;
  } exp_t;

  exp_t              sbq[$];
  exp_t              head;
  logic [DATA_W-1:0] refMem [DEPTH];
  logic [VW-1:0]     lastRsp = '0;
  int                vectors = 0;
  int                miscompares = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the whole request takes effect at acceptance.
  task automatic modelApply(input bit we, input bit vec, input logic [ADDR_W-1:0] addr,
                            input logic [VW-1:0] wdata, input int nElem,
                            output logic [VW-1:0] rsp);
    int n;
    n = vec ? VLEN : 1;
    if (nElem >= 0) n = nElem;
    rsp = '0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (int'(addr) + i) % DEPTH;
      if (we) refMem[idx] = wdata[i*DATA_W +: DATA_W];
      else    rsp[i*DATA_W +: DATA_W] = refMem[idx];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit we, input bit vec, input logic [ADDR_W-1:0] addr,
                       input logic [VW-1:0] wdata, input int abortAfter, output int waited);
    logic [VW-1:0] rsp;
    exp_t          e;
    req_valid = 1'b1;
    req_we    = we;
    req_vec   = vec;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", waited);
    end else if (abortAfter > 0) begin
      modelApply(we, vec, addr, wdata, abortAfter, rsp);
    end else begin
      modelApply(we, vec, addr, wdata, -1, rsp);
      e.data = rsp;
      e.due  = cyc + (vec ? VLEN : 1);
      sbq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  always @(posedge clk) if (reset) lastRsp = '0;

  always @(negedge clk) begin
    check("stall_vs_ready", VW'(stall), VW'(!req_ready));
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      head = sbq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_rsp: no rsp_valid by cycle %0d, expected at cycle %0d", cyc, head.due);
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        head = sbq.pop_front();
        check("rsp_data", rsp_data, head.data);
        check("rsp_cycle", VW'(cyc), VW'(head.due));
        lastRsp = head.data;
      end
    end else if (!reset) begin
      check("rsp_hold", rsp_data, lastRsp);
    end
  end

  task automatic resetPulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_rsp_valid", VW'(rsp_valid), VW'(0));
    check("rst_rsp_data", rsp_data, '0);
    check("rst_req_ready", VW'(req_ready), VW'(1));
  endtask

  function automatic logic [VW-1:0] rndVec();
    return VW'({$urandom(), $urandom()});
  endfunction

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("init_rsp_valid", VW'(rsp_valid), VW'(0));
    check("init_rsp_data", rsp_data, '0);
    check("init_req_ready", VW'(req_ready), VW'(1));
    reset = 1'b0;

    for (int a = 0; a < DEPTH; a++) issue(1'b1, 1'b0, ADDR_W'(a), rndVec(), 0, w);

    // Store then immediate load of the same word
    issue(1'b1, 1'b0, 16'h0005, VW'(16'hBEEF), 0, w);
    issue(1'b0, 1'b0, 16'h0005, '0, 0, w);
    check("b2b_ld_wait", VW'(w), VW'(0));

    // Vector store: stall for VLEN-1 cycles, then vector load back
    issue(1'b1, 1'b1, 16'h0010, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, w);
    for (int j = 0; j < VLEN - 1; j++) begin
      check("burst_stall", VW'(stall), VW'(1));
      @(negedge clk);
    end
    check("burst_end_stall", VW'(stall), VW'(0));
    issue(1'b0, 1'b1, 16'h0010, '0, 0, w);

    // Burst wrapping past the top of the array, plus aliasing
    issue(1'b1, 1'b1, 16'h03FE, rndVec(), 0, w);
    issue(1'b0, 1'b0, 16'h03FE, '0, 0, w);
    issue(1'b0, 1'b0, 16'h03FF, '0, 0, w);
    issue(1'b0, 1'b0, 16'h0000, '0, 0, w);
    issue(1'b0, 1'b0, 16'h0001, '0, 0, w);
    issue(1'b0, 1'b0, 16'h0400, '0, 0, w);
    issue(1'b0, 1'b1, 16'hFFFE, '0, 0, w);

    // Request held across a burst is accepted exactly once when ready returns
    issue(1'b1, 1'b1, 16'h0123, rndVec(), 0, w);
    issue(1'b0, 1'b0, 16'h0124, '0, 0, w);
    check("held_wait", VW'(w), VW'(VLEN - 1));

    // Reset two cycles into a vector store: only elements 0 and 1 land
    issue(1'b1, 1'b1, 16'h0020, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 2, w);
    @(negedge clk);
    resetPulse();
    for (int a = 16'h20; a <= 16'h23; a++) issue(1'b0, 1'b0, ADDR_W'(a), '0, 0, w);

    // Back-to-back scalar loads at full throughput
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 1'b0, ADDR_W'($urandom), '0, 0, w);
      check("b2b_wait", VW'(w), VW'(0));
    end

    for (int n = 0; n < 400; n++) begin
      bit we, vec;
      we  = 1'($urandom_range(0, 1));
      vec = 1'($urandom_range(0, 1));
      if (we && vec && $urandom_range(0, 19) == 0) begin
        int k;
        k = $urandom_range(1, VLEN - 1);
        issue(1'b1, 1'b1, ADDR_W'($urandom), rndVec(), k, w);
        repeat (k - 1) @(negedge clk);
        resetPulse();
      end else begin
        issue(we, vec, ADDR_W'($urandom), rndVec(), 0, w);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (VLEN + 2) @(negedge clk);
    check("drain", VW'(sbq.size()), VW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
